// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared constants and helpers for the async nibble FIFO and its
//   read-side drain logic.
//   NIBBLE_W     : data width of one FIFO entry
//   clog2        : ceiling log2, usable in constant expressions
//   creditWidth  : width needed to hold a credit count in 0..2*npw
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int NIBBLE_W = 4;

    // Smallest result such that (1 << result) >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Credits range over 0..2*npw inclusive, so 2*npw+1 distinct values.
    function automatic int creditWidth(input int npw);
        return clog2(2 * npw + 1);
    endfunction

endpackage

// File: rtl/nibble_packer.sv
// ---------------------------------------------------------------------------
// nibble_packer
//   Collects NPW nibbles into one word. A word counts as complete either when
//   all slots are already filled (held because the output register was busy)
//   or when the last slot is being captured this very cycle, so a word can
//   leave in the same cycle its final nibble arrives.
// Ports
//   clk_i       read-domain clock
//   rst_ni      asynchronous active-low reset
//   flush_i     synchronous clear of the slot count
//   capture_i   nibble_i is valid and goes into slot cnt
//   nibble_i    incoming nibble
//   load_i      the assembled word is taken this cycle; restart at slot 0
//   word_o      assembled word including any nibble captured this cycle
//   complete_o  word_o holds NPW valid nibbles
// ---------------------------------------------------------------------------
module nibble_packer
    import fifo_pkg::*;
#(
    parameter int DIN_W   = NIBBLE_W,
    parameter int NPW     = 2,
    parameter int LSB_FST = 1,
    localparam int CNT_W  = clog2(NPW + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 capture_i,
    input  logic [DIN_W-1:0]     nibble_i,
    input  logic                 load_i,
    output logic [DIN_W*NPW-1:0] word_o,
    output logic                 complete_o
);

    logic [DIN_W-1:0] slots_q  [NPW];
    logic [DIN_W-1:0] slotView [NPW];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lastSlot;

    assign lastSlot   = (cnt_q == CNT_W'(NPW - 1));
    assign complete_o = (cnt_q == CNT_W'(NPW)) | (capture_i & lastSlot);

    // Bypass the incoming nibble into its slot so a word completing this
    // cycle is visible on word_o without waiting for the slot register.
    always_comb begin
        for (int k = 0; k < NPW; k++) begin
            slotView[k] = (capture_i && (cnt_q == CNT_W'(k))) ? nibble_i : slots_q[k];
        end
    end

    // Ordering mux: slot 0 is the first nibble popped; it lands in the LSBs
    // or the MSBs of the word depending on LSB_FST.
    always_comb begin
        word_o = '0;
        for (int k = 0; k < NPW; k++) begin
            if (LSB_FST != 0) begin
                word_o[k*DIN_W +: DIN_W] = slotView[k];
            end else begin
                word_o[(NPW-1-k)*DIN_W +: DIN_W] = slotView[k];
            end
        end
    end

    // Slot count: a load always restarts at slot 0 (a capture in the same
    // cycle was the final nibble of the word being loaded).
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i || load_i) begin
            cnt_d = '0;
        end else if (capture_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Slot storage and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            for (int k = 0; k < NPW; k++) begin
                slots_q[k] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int k = 0; k < NPW; k++) begin
                if (capture_i && (cnt_q == CNT_W'(k))) begin
                    slots_q[k] <= nibble_i;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_nibble_reader.sv
// ---------------------------------------------------------------------------
// fifo_nibble_reader
//   Read-side drain engine for the 4x4 async nibble FIFO. Pops nibbles,
//   packs NPW of them into a word and offers each word on a valid/ready
//   stream. A credit counter tracks free storage (assembler slots plus the
//   output register) so a pop is only issued when its nibble has a home.
// Ports
//   rd_clk      read-domain clock
//   rst_n       asynchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO data, valid the cycle after an accepted pop
//   fifo_rd_en  pop request (combinational)
//   flush       one-cycle clear of partial and buffered data
//   m_data      packed output word
//   m_valid     m_data valid
//   m_ready     downstream accept
//   words_out   running count of handshaken words (wraps)
// ---------------------------------------------------------------------------
module fifo_nibble_reader
    import fifo_pkg::*;
#(
    parameter int DIN_W   = NIBBLE_W,
    parameter int NPW     = 2,
    parameter int LSB_FST = 1
) (
    input  logic                 rd_clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [DIN_W-1:0]     fifo_dout,
    output logic                 fifo_rd_en,
    input  logic                 flush,
    output logic [DIN_W*NPW-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [15:0]          words_out
);

    localparam int CAP    = 2 * NPW;
    localparam int CRED_W = creditWidth(NPW);

    logic [CRED_W-1:0]    credits_q, credits_d;
    logic                 inflight_q;
    logic [DIN_W*NPW-1:0] mData_q, mData_d;
    logic                 mValid_q, mValid_d;
    logic [15:0]          wordsOut_q;

    logic                 issue;
    logic                 capture;
    logic                 handshake;
    logic                 load;
    logic                 packComplete;
    logic [DIN_W*NPW-1:0] packWord;

    // rst_n is folded into the pop request because credits reset to CAP and
    // would otherwise let a pop through while the block is held in reset.
    // A nibble arriving during a flush cycle belongs to the discarded data,
    // so it is simply not captured; its credit is covered by the refill.
    assign issue      = rst_n & ~fifo_empty & (credits_q != '0) & ~flush;
    assign capture    = inflight_q & ~flush;
    assign handshake  = mValid_q & m_ready;
    assign load       = packComplete & (~mValid_q | m_ready) & ~flush;

    assign fifo_rd_en = issue;
    assign m_data     = mData_q;
    assign m_valid    = mValid_q;
    assign words_out  = wordsOut_q;

    nibble_packer #(
        .DIN_W   (DIN_W),
        .NPW     (NPW),
        .LSB_FST (LSB_FST)
    ) uPacker (
        .clk_i      (rd_clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .capture_i  (capture),
        .nibble_i   (fifo_dout),
        .load_i     (load),
        .word_o     (packWord),
        .complete_o (packComplete)
    );

    // Credits: one consumed per pop, NPW returned per handshaken word.
    // Flush empties all storage, so the full capacity comes back.
    always_comb begin
        credits_d = credits_q;
        if (flush) begin
            credits_d = CRED_W'(CAP);
        end else begin
            if (issue) begin
                credits_d = credits_d - CRED_W'(1);
            end
            if (handshake) begin
                credits_d = credits_d + CRED_W'(NPW);
            end
        end
    end

    // Output register: loads only when empty or being drained, so m_data
    // holds steady while a word waits for m_ready.
    always_comb begin
        mValid_d = mValid_q;
        mData_d  = mData_q;
        if (flush) begin
            mValid_d = 1'b0;
            mData_d  = '0;
        end else if (load) begin
            mValid_d = 1'b1;
            mData_d  = packWord;
        end else if (handshake) begin
            mValid_d = 1'b0;
        end
    end

    // State registers. words_out counts every handshake, flush or not.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q  <= CRED_W'(CAP);
            inflight_q <= 1'b0;
            mData_q    <= '0;
            mValid_q   <= 1'b0;
            wordsOut_q <= '0;
        end else begin
            credits_q  <= credits_d;
            inflight_q <= issue;
            mData_q    <= mData_d;
            mValid_q   <= mValid_d;
            if (handshake) begin
                wordsOut_q <= wordsOut_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_nibble_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_nibble_reader
//   Drives two readers (LSB-first and MSB-first) from one emulated FIFO.
//   The reference model is a queue of nibbles that have been popped but not
//   yet handed downstream: its length is the storage in use, its front NPW
//   entries form the next word, a flush empties it.
// ---------------------------------------------------------------------------
module tb_fifo_nibble_reader;

    localparam int DIN_W  = 4;
    localparam int NPW    = 2;
    localparam int CAP    = 2 * NPW;
    localparam int WORD_W = DIN_W * NPW;

    logic              rdClk     = 1'b0;
    logic              rstN      = 1'b0;
    logic              fifoEmpty = 1'b1;
    logic [DIN_W-1:0]  fifoDout  = '0;
    logic              flush     = 1'b0;
    logic              mReady    = 1'b0;

    logic              fifoRdEn, fifoRdEnMsb;
    logic [WORD_W-1:0] mData, mDataMsb;
    logic              mValid, mValidMsb;
    logic [15:0]       wordsOut, wordsOutMsb;

    int                testsRun  = 0;
    int                failCount = 0;

    logic [DIN_W-1:0]  fifoQ  [$];
    logic [DIN_W-1:0]  modelQ [$];
    logic [WORD_W-1:0] hsLog  [$];
    int                popCount    = 0;
    logic [15:0]       hsCount     = '0;
    logic              popPending  = 1'b0;
    logic              prevHold    = 1'b0;
    logic              prevFlush   = 1'b0;
    logic [WORD_W-1:0] prevData    = '0;
    logic              expRdEn;
    logic [DIN_W-1:0]  popVal;

    always #5 rdClk = ~rdClk;

    fifo_nibble_reader #(.DIN_W(DIN_W), .NPW(NPW), .LSB_FST(1)) dut (
        .rd_clk     (rdClk),
        .rst_n      (rstN),
        .fifo_empty (fifoEmpty),
        .fifo_dout  (fifoDout),
        .fifo_rd_en (fifoRdEn),
        .flush      (flush),
        .m_data     (mData),
        .m_valid    (mValid),
        .m_ready    (mReady),
        .words_out  (wordsOut)
    );

    fifo_nibble_reader #(.DIN_W(DIN_W), .NPW(NPW), .LSB_FST(0)) dutMsb (
        .rd_clk     (rdClk),
        .rst_n      (rstN),
        .fifo_empty (fifoEmpty),
        .fifo_dout  (fifoDout),
        .fifo_rd_en (fifoRdEnMsb),
        .flush      (flush),
        .m_data     (mDataMsb),
        .m_valid    (mValidMsb),
        .m_ready    (mReady),
        .words_out  (wordsOutMsb)
    );

    // One comparison: bump the run count, report and count any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Packs the oldest NPW model nibbles; first popped nibble in the LSBs
    // or the MSBs.
    function automatic logic [WORD_W-1:0] packFront(input bit lsbFirst);
        logic [WORD_W-1:0] w;
        int slot;
        w = '0;
        for (int k = 0; k < NPW; k++) begin
            slot = lsbFirst ? k : (NPW - 1 - k);
            w[slot*DIN_W +: DIN_W] = modelQ[k];
        end
        return w;
    endfunction

    // Advance to the next cycle and drive the handshake/flush inputs there.
    task automatic applyStimulus(input logic ready, input logic fl);
        @(posedge rdClk);
        #2;
        mReady    = ready;
        flush     = fl;
        fifoEmpty = (fifoQ.size() == 0);
    endtask

    task automatic pushNibble(input logic [DIN_W-1:0] v);
        fifoQ.push_back(v);
        fifoEmpty = 1'b0;
    endtask

    // Bounded wait for m_valid, then compare the word that shows up.
    task automatic waitValid(input logic [WORD_W-1:0] expData, input string name);
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge rdClk);
            if (mValid) begin
                seen = 1;
                checkOutput(name, mData, expData);
            end
        end
        if (!seen) checkOutput({name, "Timeout"}, 0, 1);
    endtask

    // FIFO emulation: a pop requested during the previous cycle delivers
    // its nibble shortly after the edge; the model records it as stored.
    always @(posedge rdClk) begin
        #1;
        if (rstN && popPending && fifoQ.size() > 0) begin
            popVal   = fifoQ.pop_front();
            fifoDout = popVal;
            modelQ.push_back(popVal);
            popCount++;
        end
        popPending = 1'b0;
        fifoEmpty  = (fifoQ.size() == 0);
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge rdClk) begin
        if (!rstN) begin
            checkOutput("rdEnInReset", fifoRdEn, 0);
            checkOutput("validInReset", mValid, 0);
            checkOutput("wordsInReset", wordsOut, 0);
            modelQ.delete();
            hsCount    = '0;
            popPending = 1'b0;
            prevHold   = 1'b0;
            prevFlush  = 1'b0;
        end else begin
            expRdEn = !fifoEmpty && !flush && (modelQ.size() < CAP);
            checkOutput("rdEn", fifoRdEn, expRdEn);
            checkOutput("rdEnMsb", fifoRdEnMsb, expRdEn);
            checkOutput("wordsOut", wordsOut, hsCount);
            checkOutput("wordsOutMsb", wordsOutMsb, hsCount);
            checkOutput("creditInvariant",
                        32'(dut.credits_q) + 32'(dut.inflight_q) + 32'(dut.uPacker.cnt_q)
                        + (mValid ? NPW : 0), CAP);
            if (prevFlush) begin
                checkOutput("validAfterFlush", mValid, 0);
                checkOutput("dataAfterFlush", mData, 0);
            end
            if (prevHold) begin
                checkOutput("holdValid", mValid, 1);
                checkOutput("holdData", mData, prevData);
            end
            if (mValid && mReady) begin
                if (modelQ.size() < NPW) begin
                    checkOutput("wordAvailable", modelQ.size(), NPW);
                end else begin
                    checkOutput("wordData", mData, packFront(1));
                    checkOutput("wordDataMsb", mDataMsb, packFront(0));
                    checkOutput("validMsb", mValidMsb, 1);
                    for (int k = 0; k < NPW; k++) void'(modelQ.pop_front());
                end
                hsLog.push_back(mData);
                hsCount++;
            end
            popPending = fifoRdEn;
            prevHold   = mValid && !mReady && !flush;
            prevData   = mData;
            prevFlush  = flush;
            if (flush) modelQ.delete();
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int popBase;
        int hsBase;

        // Reset state.
        rstN = 1'b0;
        repeat (3) @(posedge rdClk);
        #2;
        rstN = 1'b1;
        @(negedge rdClk);
        checkOutput("resetValid", mValid, 0);
        checkOutput("resetData", mData, 0);
        checkOutput("resetWords", wordsOut, 0);
        checkOutput("resetCredits", 32'(dut.credits_q), 4);

        // 0x1 then 0x2: word 0x21 (0x12 MSB-first) three cycles after empty falls.
        applyStimulus(1'b1, 1'b0);
        pushNibble(4'h1);
        pushNibble(4'h2);
        @(negedge rdClk);
        @(negedge rdClk);
        @(negedge rdClk);
        checkOutput("latencyNotEarly", mValid, 0);
        @(negedge rdClk);
        checkOutput("latencyValid", mValid, 1);
        checkOutput("firstWordLsb", mData, 8'h21);
        checkOutput("firstWordMsb", mDataMsb, 8'h12);
        @(negedge rdClk);
        checkOutput("singleCycleValid", mValid, 0);
        checkOutput("wordsAfterFirst", wordsOut, 1);

        // Stalled downstream: credits stop popping at four nibbles.
        popBase = popCount;
        applyStimulus(1'b0, 1'b0);
        for (int v = 1; v <= 6; v++) pushNibble(4'(v));
        repeat (10) applyStimulus(1'b0, 1'b0);
        @(negedge rdClk);
        checkOutput("stallPops", popCount - popBase, 4);
        checkOutput("stallRdEn", fifoRdEn, 0);
        checkOutput("stallFifoLeft", fifoQ.size(), 2);
        checkOutput("stallValid", mValid, 1);
        checkOutput("stallData", mData, 8'h21);
        hsBase = hsLog.size();
        repeat (10) applyStimulus(1'b1, 1'b0);
        @(negedge rdClk);
        checkOutput("drainCount", hsLog.size() - hsBase, 3);
        if (hsLog.size() - hsBase >= 3) begin
            checkOutput("drainWord0", hsLog[hsBase], 8'h21);
            checkOutput("drainWord1", hsLog[hsBase + 1], 8'h43);
            checkOutput("drainWord2", hsLog[hsBase + 2], 8'h65);
        end

        // Flush with one nibble captured and one in flight.
        applyStimulus(1'b1, 1'b0);
        pushNibble(4'h7);
        pushNibble(4'h8);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        @(negedge rdClk);
        checkOutput("cntBeforeFlush", 32'(dut.uPacker.cnt_q), 1);
        checkOutput("inflightAtFlush", dut.inflight_q, 1);
        applyStimulus(1'b1, 1'b0);
        @(negedge rdClk);
        checkOutput("flushValid", mValid, 0);
        checkOutput("flushCredits", 32'(dut.credits_q), 4);
        checkOutput("flushCnt", 32'(dut.uPacker.cnt_q), 0);
        applyStimulus(1'b1, 1'b0);
        pushNibble(4'hA);
        pushNibble(4'hB);
        waitValid(8'hBA, "afterFlushWord");

        // Reset in the middle of a word with a word waiting at the output.
        applyStimulus(1'b0, 1'b0);
        pushNibble(4'h3);
        pushNibble(4'h4);
        pushNibble(4'h5);
        repeat (6) applyStimulus(1'b0, 1'b0);
        @(negedge rdClk);
        checkOutput("preResetValid", mValid, 1);
        checkOutput("preResetData", mData, 8'h43);
        checkOutput("preResetCnt", 32'(dut.uPacker.cnt_q), 1);
        applyStimulus(1'b0, 1'b0);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("asyncResetValid", mValid, 0);
        checkOutput("asyncResetValidMsb", mValidMsb, 0);
        checkOutput("asyncResetWords", wordsOut, 0);
        pushNibble(4'hC);
        #1;
        checkOutput("resetRdEn", fifoRdEn, 0);
        repeat (2) applyStimulus(1'b1, 1'b0);
        rstN = 1'b1;

        // A lone nibble stays parked: no padding, no timeout.
        repeat (3) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge rdClk);
            checkOutput("partialWaits", mValid, 0);
        end
        checkOutput("partialCnt", 32'(dut.uPacker.cnt_q), 1);

        // Random fill, random ready, rare flush.
        hsBase = hsLog.size();
        for (int c = 0; c < 10000; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
            if (fifoQ.size() < 4 && $urandom_range(0, 1) == 1) begin
                pushNibble(4'($urandom_range(0, 15)));
            end
        end
        repeat (20) applyStimulus(1'b1, 1'b0);
        @(negedge rdClk);
        checkOutput("randomFifoDrained", fifoQ.size(), 0);
        checkOutput("randomResidue", modelQ.size() < NPW, 1);
        checkOutput("randomWordsSeen", (hsLog.size() - hsBase) > 500, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
